// File: rtl/whistle_pkg.sv
// Shared definitions for the whistle tone path: FSM state encodings,
// default Q-format constants and helpers for sizing saturation bounds.
package whistle_pkg;

    localparam int DEF_FRAC_W = 20;
    localparam int DEF_OUT_W  = 8;

    // state     | meaning
    // ST_IDLE   | no tone playing, output parked at midscale
    // ST_RUN    | emitting samples, one per divided tick
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Signed Q2.DEF_FRAC_W constants for the default oscillator width.
    localparam logic signed [DEF_FRAC_W+1:0] ONE      = {2'b01, {DEF_FRAC_W{1'b0}}};
    localparam logic signed [DEF_FRAC_W+1:0] SAT_MAX  = {2'b01, {DEF_FRAC_W{1'b1}}};
    localparam logic signed [DEF_FRAC_W+1:0] SAT_MIN  = {2'b10, {DEF_FRAC_W{1'b0}}};
    localparam logic        [DEF_OUT_W-1:0]  MIDSCALE = {1'b1, {(DEF_OUT_W-1){1'b0}}};

    // Saturation bounds of a Q2.frac_w value, as 64-bit signed integers so
    // any datapath width up to 64 bits can compare against them.
    function automatic longint q_sat_max(input int frac_w);
        return (64'sd1 <<< (frac_w + 1)) - 64'sd1;
    endfunction

    function automatic longint q_sat_min(input int frac_w);
        return -(64'sd1 <<< (frac_w + 1));
    endfunction

endpackage

// File: rtl/whistle_tone_gen_tick_gen.sv
// Sample-rate divider: one-cycle tick every TICK_DIV enabled clocks.
// restart_i (or dropping en_i) returns the count to zero synchronously.
module tick_gen #(
    parameter int TICK_DIV = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TC = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count up while enabled, wrap at terminal count, clear on restart.
    always_comb begin
        cnt_d = cnt_q;
        if (restart_i || !en_i) begin
            cnt_d = '0;
        end else if (cnt_q == TC) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && !restart_i && (cnt_q == TC);

endmodule

// File: rtl/whistle_tone_gen.sv
// Triggerable cosine tone generator built on a two-pole recursive
// oscillator x[n] = coef*x[n-1] - x[n-2], emitting offset-binary samples
// at a divided rate for the PWM stage.
// Optional build macro WHISTLE_FADE_EN adds a release ramp that deepens
// the attenuation shift over the last 8 samples of a tone.
module whistle_tone_gen
    import whistle_pkg::*;
#(
    parameter int FRAC_W   = 20,
    parameter int OUT_W    = 8,
    parameter int TICK_DIV = 256,
    parameter int DUR_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic signed [FRAC_W+1:0] coef,
    input  logic        [DUR_W-1:0]  duration,
    input  logic        [2:0]        atten,
    output logic        [OUT_W-1:0]  sample,
    output logic                     sample_valid,
    output logic                     en_pwm,
    output logic                     busy,
    output logic                     done
);

    localparam int X_W        = FRAC_W + 2;
    localparam int PROD_W     = 2 * FRAC_W + 4;
    localparam int SHIFT_BASE = FRAC_W - OUT_W + 2;

    localparam logic signed [X_W-1:0]   ONE_Q  = {2'b01, {FRAC_W{1'b0}}};
    localparam logic        [OUT_W-1:0] MID_C  = {1'b1, {(OUT_W-1){1'b0}}};
    localparam longint                  SMAX_L = q_sat_max(FRAC_W);
    localparam longint                  SMIN_L = q_sat_min(FRAC_W);

    logic [0:0]            state_q, state_d;
    logic signed [X_W-1:0] coef_q, coef_d;
    logic [2:0]            atten_q, atten_d;
    logic [DUR_W-1:0]      rem_q, rem_d;
    logic signed [X_W-1:0] x_prev_q, x_prev_d;
    logic signed [X_W-1:0] x_pprev_q, x_pprev_d;
    logic [OUT_W-1:0]      sample_q, sample_d;
    logic                  sample_valid_q, sample_valid_d;
    logic                  done_q, done_d;

    logic                  start_acc;
    logic                  tick;
    logic [4:0]            shift;
    logic signed [PROD_W-1:0] prod, prod_rs, diff;
    logic signed [63:0]    diff64;
    logic signed [X_W-1:0] x_next;
    logic signed [X_W-1:0] scaled_a, scaled_b;
    logic [OUT_W-1:0]      sample_tick;

    assign start_acc = (state_q == ST_IDLE) && start && (duration != '0);

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk       (clk),
        .rst       (rst),
        .en_i      (state_q == ST_RUN),
        .restart_i (start_acc),
        .tick_o    (tick)
    );

`ifdef WHISTLE_FADE_EN
    logic [3:0] fade_extra;
    logic [4:0] fade_sum;

    // Release ramp: add (8 - remaining) to the shift over the last 8 samples.
    always_comb begin
        fade_extra = '0;
        if (rem_q < DUR_W'(8)) begin
            fade_extra = 4'd8 - {1'b0, rem_q[2:0]};
        end
        fade_sum = {2'b00, atten_q} + {1'b0, fade_extra};
        shift    = (fade_sum > 5'(OUT_W - 1)) ? 5'(OUT_W - 1) : fade_sum;
    end
`else
    assign shift = {2'b00, atten_q};
`endif

    // Oscillator update and sample formatting; the recurrence is evaluated
    // at full product width so nothing wraps before the clamp to Q2 range.
    always_comb begin
        prod     = PROD_W'(coef_q) * PROD_W'(x_prev_q);
        prod_rs  = prod >>> FRAC_W;
        diff     = prod_rs - PROD_W'(x_pprev_q);
        diff64   = 64'(diff);
        if (diff64 > SMAX_L) begin
            x_next = {2'b01, {FRAC_W{1'b1}}};
        end else if (diff64 < SMIN_L) begin
            x_next = {2'b10, {FRAC_W{1'b0}}};
        end else begin
            x_next = diff64[X_W-1:0];
        end
        scaled_a    = x_pprev_q >>> SHIFT_BASE;
        scaled_b    = scaled_a >>> shift;
        sample_tick = scaled_b[OUT_W-1:0] + MID_C;
    end

    // Next-state logic for the IDLE/RUN controller.
    always_comb begin
        state_d        = state_q;
        coef_d         = coef_q;
        atten_d        = atten_q;
        rem_d          = rem_q;
        x_prev_d       = x_prev_q;
        x_pprev_d      = x_pprev_q;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        done_d         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (duration != '0) begin
                        coef_d    = coef;
                        atten_d   = atten;
                        rem_d     = duration;
                        x_prev_d  = coef >>> 1;
                        x_pprev_d = ONE_Q;
                        state_d   = ST_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (stop || (rem_q == '0)) begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    sample_d = MID_C;
                end else if (tick) begin
                    sample_d       = sample_tick;
                    sample_valid_d = 1'b1;
                    x_pprev_d      = x_prev_q;
                    x_prev_d       = x_next;
                    rem_d          = rem_q - DUR_W'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                sample_d = MID_C;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            coef_q         <= '0;
            atten_q        <= '0;
            rem_q          <= '0;
            x_prev_q       <= '0;
            x_pprev_q      <= '0;
            sample_q       <= MID_C;
            sample_valid_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            coef_q         <= coef_d;
            atten_q        <= atten_d;
            rem_q          <= rem_d;
            x_prev_q       <= x_prev_d;
            x_pprev_q      <= x_pprev_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            done_q         <= done_d;
        end
    end

    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign en_pwm       = (state_q == ST_RUN);
    assign busy         = (state_q == ST_RUN);
    assign done         = done_q;

endmodule

// File: tb/tb_whistle_tone_gen.sv
// Scoreboard bench for whistle_tone_gen: stimulus pushes expected samples,
// a negedge monitor pops and compares each sample_valid pulse and checks
// the TICK_DIV spacing between samples.
module tb_whistle_tone_gen;

    localparam int FRAC_W   = 20;
    localparam int OUT_W    = 8;
    localparam int TICK_DIV = 256;
    localparam int DUR_W    = 16;

    logic                     clk;
    logic                     rst;
    logic                     start;
    logic                     stop;
    logic signed [FRAC_W+1:0] coef;
    logic        [DUR_W-1:0]  duration;
    logic        [2:0]        atten;
    logic        [OUT_W-1:0]  sample;
    logic                     sample_valid;
    logic                     en_pwm;
    logic                     busy;
    logic                     done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int tone_ref = 0;
    int last_sv  = -1;
    int exp_q[$];

    whistle_tone_gen #(
        .FRAC_W   (FRAC_W),
        .OUT_W    (OUT_W),
        .TICK_DIV (TICK_DIV),
        .DUR_W    (DUR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .coef         (coef),
        .duration     (duration),
        .atten        (atten),
        .sample       (sample),
        .sample_valid (sample_valid),
        .en_pwm       (en_pwm),
        .busy         (busy),
        .done         (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: each sample_valid pops one expected value and must land
    // exactly TICK_DIV cycles after the start edge or the previous sample.
    always @(negedge clk) begin
        if (!rst && sample_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sample_valid", 1, 0);
            end else begin
                check("sample_value", int'(sample), exp_q.pop_front());
            end
            check("sample_spacing", cyc - tone_ref, TICK_DIV);
            tone_ref = cyc;
            last_sv  = cyc;
        end
    end

    task automatic start_tone(input logic signed [FRAC_W+1:0] c, input int d,
                              input int a, input logic with_stop);
        @(negedge clk);
        coef     = c;
        duration = DUR_W'(d);
        atten    = 3'(a);
        start    = 1'b1;
        stop     = with_stop;
        @(posedge clk);
        #1 tone_ref = cyc;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic wait_samples(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("samples_drained", exp_q.size(), 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_sample_mid"}, int'(sample), 128);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_en_pwm"}, int'(en_pwm), 0);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic normal_end(input string tag);
        wait_done(TICK_DIV * 8);
        check({tag, "_done_after_last"}, cyc - last_sv, 1);
        check_idle(tag);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, int'(done), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        coef     = '0;
        duration = '0;
        atten    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_sample", int'(sample), 128);
        check("reset_valid", int'(sample_valid), 0);
        check("reset_en_pwm", int'(en_pwm), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);

        // w0 = pi/2: 1, 0, -1, 0, 1
        exp_q = '{192, 128, 64, 128, 192};
        start_tone(22'sh000000, 5, 0, 1'b0);
        check("t1_busy", int'(busy), 1);
        check("t1_en_pwm", int'(en_pwm), 1);
        normal_end("t1");

        // coef = -2.0: alternating +1/-1, no saturation
        exp_q = '{192, 64, 192, 64};
        start_tone(22'sh200000, 4, 0, 1'b0);
        normal_end("t2");

        // attenuation by 2, plus a start while busy that must be ignored
        exp_q = '{144, 128, 112, 128};
        start_tone(22'sh000000, 4, 2, 1'b0);
        repeat (TICK_DIV + 10) @(negedge clk);
        coef     = 22'sh200000;
        duration = DUR_W'(1);
        atten    = 3'd0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t3_busy_after_ignored_start", int'(busy), 1);
        normal_end("t3");

        // stop after the third sample of a long tone
        exp_q = '{192, 128, 64};
        start_tone(22'sh000000, 100, 0, 1'b0);
        wait_samples(TICK_DIV * 5);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("t4_done_on_stop", int'(done), 1);
        check_idle("t4");
        repeat (2 * TICK_DIV) @(negedge clk);
        check("t4_still_idle", int'(busy), 0);

        // zero duration: done next cycle, never busy, no samples
        start_tone(22'sh000000, 0, 0, 1'b0);
        check("t5_done_dur0", int'(done), 1);
        check("t5_busy_dur0", int'(busy), 0);
        repeat (TICK_DIV + 4) @(negedge clk);
        check_idle("t5");

        // start and stop together in IDLE: start wins
        exp_q = '{192, 128};
        start_tone(22'sh000000, 2, 0, 1'b1);
        check("t6_busy_start_wins", int'(busy), 1);
        normal_end("t6");

        // asynchronous reset in the middle of a tone
        exp_q = '{192, 128};
        start_tone(22'sh000000, 5, 0, 1'b0);
        wait_samples(TICK_DIV * 4);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t7_rst_sample", int'(sample), 128);
        check("t7_rst_busy", int'(busy), 0);
        check("t7_rst_en_pwm", int'(en_pwm), 0);
        check("t7_rst_done", int'(done), 0);
        check("t7_rst_valid", int'(sample_valid), 0);
        @(negedge clk);
        rst = 1'b0;

        // fresh tone after reset: tick counter restarted cleanly
        exp_q = '{192, 64};
        start_tone(22'sh200000, 2, 0, 1'b0);
        normal_end("t8");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
